// File: rtl/tetris_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tetris_pkg - board geometry, 3:3:3 colours and paint scheduler state encoding
// Rev 1.0
// ----------------------------------------------------------------------------
package tetris_pkg;

    localparam int COLS   = 10;
    localparam int ROWS   = 20;
    localparam int CELL_W = 64;
    localparam int CELL_H = 24;

    localparam logic [8:0] COLOR_BLACK = 9'h000;
    localparam logic [8:0] COLOR_WHITE = 9'h1FF;
    localparam logic [8:0] BG_COLOR    = COLOR_BLACK;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2
    } state_t;

    // Products are truncated to the painter's origin widths.
    function automatic logic [9:0] cell_px_x(input logic [3:0] x, input int cw);
        return 10'(int'(x) * cw);
    endfunction

    function automatic logic [8:0] cell_px_y(input logic [4:0] y, input int ch);
        return 9'(int'(y) * ch);
    endfunction

endpackage
`default_nettype wire

// File: rtl/rr_arbiter.sv
`default_nettype none
// ----------------------------------------------------------------------------
// rr_arbiter - combinational round-robin pick, searching from last_grant+1
// Rev 1.0
// ----------------------------------------------------------------------------
module rr_arbiter #(
    parameter int NREQ = 4,
    parameter int IW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic [NREQ-1:0] req_i,
    input  logic [IW-1:0]   last_grant_i,
    output logic [NREQ-1:0] grant_o,
    output logic [IW-1:0]   grant_idx_o,
    output logic            any_o
);

    always_comb begin
        int idx;
        idx         = 0;
        grant_o     = '0;
        grant_idx_o = '0;
        any_o       = 1'b0;
        for (int k = 1; k <= NREQ; k++) begin
            idx = (int'(last_grant_i) + k) % NREQ;
            if (!any_o && req_i[IW'(idx)]) begin
                grant_o[IW'(idx)] = 1'b1;
                grant_idx_o       = IW'(idx);
                any_o             = 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/paint_scheduler.sv
`default_nettype none
// ----------------------------------------------------------------------------
// paint_scheduler - shares the box painter between cell-draw requesters and
//                   the full-board clear sweep
// Rev 1.0
// ----------------------------------------------------------------------------
module paint_scheduler #(
    parameter int         NREQ        = 4,
    parameter int         COLS        = tetris_pkg::COLS,
    parameter int         ROWS        = tetris_pkg::ROWS,
    parameter int         CELL_W      = tetris_pkg::CELL_W,
    parameter int         CELL_H      = tetris_pkg::CELL_H,
    parameter logic [8:0] BG_COLOR    = tetris_pkg::BG_COLOR,
    parameter int         TIMEOUT_CYC = 4096
) (
    input  logic              CLOCK_50,
    input  logic              resetn,
    input  logic [NREQ-1:0]   req,
    input  logic [4*NREQ-1:0] req_x,
    input  logic [5*NREQ-1:0] req_y,
    input  logic [9*NREQ-1:0] req_color,
    output logic [NREQ-1:0]   ack,
    input  logic              clear_req,
    output logic              clear_busy,
    output logic              p_start,
    output logic [9:0]        p_x0,
    output logic [8:0]        p_y0,
    output logic [8:0]        p_color,
    input  logic              p_busy,
    input  logic              p_done,
    output logic              err_timeout,
    output logic              err_range
);
    import tetris_pkg::*;

    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int TW = $clog2(TIMEOUT_CYC + 1);

    state_t            state_q, state_d;
    logic [NREQ-1:0]   ack_q, ack_d;
    logic              p_start_q, p_start_d;
    logic [9:0]        p_x0_q, p_x0_d;
    logic [8:0]        p_y0_q, p_y0_d;
    logic [8:0]        p_color_q, p_color_d;
    logic              op_clr_q, op_clr_d;
    logic [IW-1:0]     grant_q, grant_d;
    logic [IW-1:0]     last_grant_q, last_grant_d;
    logic              clr_pend_q, clr_pend_d;
    logic [3:0]        clr_x_q, clr_x_d;
    logic [4:0]        clr_y_q, clr_y_d;
    logic [TW-1:0]     to_cnt_q, to_cnt_d;
    logic              err_timeout_q, err_timeout_d;
    logic              err_range_q, err_range_d;

    logic [NREQ-1:0]   arb_grant;
    logic [IW-1:0]     arb_idx;
    logic              arb_any;
    logic [3:0]        x_arr [NREQ];
    logic [4:0]        y_arr [NREQ];
    logic [8:0]        c_arr [NREQ];
    logic [3:0]        win_x;
    logic [4:0]        win_y;
    logic [8:0]        win_color;

    genvar gi;
    generate
        for (gi = 0; gi < NREQ; gi++) begin : g_unpack
            assign x_arr[gi] = req_x[4*gi +: 4];
            assign y_arr[gi] = req_y[5*gi +: 5];
            assign c_arr[gi] = req_color[9*gi +: 9];
        end
    endgenerate

    assign win_x     = x_arr[arb_idx];
    assign win_y     = y_arr[arb_idx];
    assign win_color = c_arr[arb_idx];

    // A requester is masked while its ack is high so it may drop req a cycle late.
    rr_arbiter #(.NREQ(NREQ), .IW(IW)) u_arb (
        .req_i        (req & ~ack_q),
        .last_grant_i (last_grant_q),
        .grant_o      (arb_grant),
        .grant_idx_o  (arb_idx),
        .any_o        (arb_any)
    );

    always_comb begin
        state_d       = state_q;
        ack_d         = '0;
        p_start_d     = 1'b0;
        p_x0_d        = p_x0_q;
        p_y0_d        = p_y0_q;
        p_color_d     = p_color_q;
        op_clr_d      = op_clr_q;
        grant_d       = grant_q;
        last_grant_d  = last_grant_q;
        clr_pend_d    = clr_pend_q;
        clr_x_d       = clr_x_q;
        clr_y_d       = clr_y_q;
        to_cnt_d      = to_cnt_q;
        err_timeout_d = err_timeout_q;
        err_range_d   = err_range_q;

        case (state_q)
            ST_IDLE: begin
                if (clr_pend_q && !p_busy) begin
                    op_clr_d  = 1'b1;
                    p_x0_d    = cell_px_x(clr_x_q, CELL_W);
                    p_y0_d    = cell_px_y(clr_y_q, CELL_H);
                    p_color_d = BG_COLOR;
                    p_start_d = 1'b1;
                    state_d   = ST_ISSUE;
                end else if (arb_any && !p_busy) begin
                    if (int'(win_x) >= COLS || int'(win_y) >= ROWS) begin
                        ack_d        = arb_grant;
                        err_range_d  = 1'b1;
                        last_grant_d = arb_idx;
                    end else begin
                        op_clr_d  = 1'b0;
                        grant_d   = arb_idx;
                        p_x0_d    = cell_px_x(win_x, CELL_W);
                        p_y0_d    = cell_px_y(win_y, CELL_H);
                        p_color_d = win_color;
                        p_start_d = 1'b1;
                        state_d   = ST_ISSUE;
                    end
                end
            end
            ST_ISSUE: begin
                to_cnt_d = '0;
                state_d  = ST_WAIT;
            end
            ST_WAIT: begin
                // A timed-out op is retired exactly like a completed one.
                if (p_done || int'(to_cnt_q) == TIMEOUT_CYC - 1) begin
                    if (!p_done) begin
                        err_timeout_d = 1'b1;
                    end
                    state_d = ST_IDLE;
                    if (op_clr_q) begin
                        if (int'(clr_x_q) == COLS - 1) begin
                            clr_x_d = '0;
                            if (int'(clr_y_q) == ROWS - 1) begin
                                clr_y_d    = '0;
                                clr_pend_d = 1'b0;
                            end else begin
                                clr_y_d = clr_y_q + 5'd1;
                            end
                        end else begin
                            clr_x_d = clr_x_q + 4'd1;
                        end
                    end else begin
                        ack_d[grant_q] = 1'b1;
                        last_grant_d   = grant_q;
                    end
                end else begin
                    to_cnt_d = to_cnt_q + TW'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Pending flag already covers a running sweep, so repeats are absorbed.
        if (clear_req) begin
            clr_pend_d = 1'b1;
        end
    end

    always_ff @(posedge CLOCK_50) begin
        if (!resetn) begin
            state_q       <= ST_IDLE;
            ack_q         <= '0;
            p_start_q     <= 1'b0;
            p_x0_q        <= '0;
            p_y0_q        <= '0;
            p_color_q     <= '0;
            op_clr_q      <= 1'b0;
            grant_q       <= '0;
            last_grant_q  <= '0;
            clr_pend_q    <= 1'b1;
            clr_x_q       <= '0;
            clr_y_q       <= '0;
            to_cnt_q      <= '0;
            err_timeout_q <= 1'b0;
            err_range_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            ack_q         <= ack_d;
            p_start_q     <= p_start_d;
            p_x0_q        <= p_x0_d;
            p_y0_q        <= p_y0_d;
            p_color_q     <= p_color_d;
            op_clr_q      <= op_clr_d;
            grant_q       <= grant_d;
            last_grant_q  <= last_grant_d;
            clr_pend_q    <= clr_pend_d;
            clr_x_q       <= clr_x_d;
            clr_y_q       <= clr_y_d;
            to_cnt_q      <= to_cnt_d;
            err_timeout_q <= err_timeout_d;
            err_range_q   <= err_range_d;
        end
    end

    assign ack         = ack_q;
    assign clear_busy  = clr_pend_q;
    assign p_start     = p_start_q;
    assign p_x0        = p_x0_q;
    assign p_y0        = p_y0_q;
    assign p_color     = p_color_q;
    assign err_timeout = err_timeout_q;
    assign err_range   = err_range_q;

endmodule
`default_nettype wire

// File: tb/tb_paint_scheduler.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_paint_scheduler - directed scenarios for paint_scheduler with a painter model
// Rev 1.0
// ----------------------------------------------------------------------------
module tb_paint_scheduler;

    localparam int NREQ = 4;
    localparam int TOUT = 4096;

    logic              CLOCK_50 = 1'b0;
    logic              resetn   = 1'b0;
    logic [NREQ-1:0]   req      = '0;
    logic [4*NREQ-1:0] req_x    = '0;
    logic [5*NREQ-1:0] req_y    = '0;
    logic [9*NREQ-1:0] req_color = '0;
    logic [NREQ-1:0]   ack;
    logic              clear_req = 1'b0;
    logic              clear_busy;
    logic              p_start;
    logic [9:0]        p_x0;
    logic [8:0]        p_y0;
    logic [8:0]        p_color;
    logic              p_busy;
    logic              p_done;
    logic              err_timeout;
    logic              err_range;

    logic              hang = 1'b0;
    logic [2:0]        pcnt;
    int                checks   = 0;
    int                failures = 0;

    always #5 CLOCK_50 = ~CLOCK_50;

    paint_scheduler #(
        .NREQ(NREQ), .COLS(10), .ROWS(20), .CELL_W(64), .CELL_H(24),
        .BG_COLOR(9'd0), .TIMEOUT_CYC(TOUT)
    ) dut (
        .CLOCK_50(CLOCK_50), .resetn(resetn), .req(req), .req_x(req_x),
        .req_y(req_y), .req_color(req_color), .ack(ack), .clear_req(clear_req),
        .clear_busy(clear_busy), .p_start(p_start), .p_x0(p_x0), .p_y0(p_y0),
        .p_color(p_color), .p_busy(p_busy), .p_done(p_done),
        .err_timeout(err_timeout), .err_range(err_range)
    );

    // Painter model: busy after start, done pulse a few cycles later; hang never answers.
    always @(posedge CLOCK_50) begin
        if (!resetn) begin
            p_busy <= 1'b0;
            p_done <= 1'b0;
            pcnt   <= '0;
        end else begin
            p_done <= 1'b0;
            if (p_start && !hang) begin
                p_busy <= 1'b1;
                pcnt   <= '0;
            end else if (p_busy) begin
                if (pcnt == 3'd3) begin
                    p_busy <= 1'b0;
                    p_done <= 1'b1;
                end else begin
                    pcnt <= pcnt + 3'd1;
                end
            end
        end
    end

    task automatic tick();
        @(negedge CLOCK_50);
    endtask

    task automatic set_req(input int i, input int x, input int y, input logic [8:0] c);
        req_x     = (req_x & ~(16'hF << (4*i))) | (16'(x) << (4*i));
        req_y     = (req_y & ~(20'h1F << (5*i))) | (20'(y) << (5*i));
        req_color = (req_color & ~(36'h1FF << (9*i))) | (36'(c) << (9*i));
    endtask

    task automatic test_reset();
        logic [35:0] got;
        resetn = 1'b0; req = '0; clear_req = 1'b0; hang = 1'b0;
        repeat (3) tick();
        got = {p_start, p_x0, p_y0, p_color, ack, err_timeout, err_range, clear_busy};
        checks++;
        if (got !== {1'b0, 10'd0, 9'd0, 9'd0, 4'd0, 1'b0, 1'b0, 1'b1}) begin
            failures++;
            $display("FAIL reset_state got=%h exp=%h", got, {1'b0, 10'd0, 9'd0, 9'd0, 4'd0, 3'b001});
        end
    endtask

    task automatic test_clear_sweep();
        logic [27:0] st[$];
        logic [27:0] expv;
        int acks, last_done, fall;
        acks = 0; last_done = -1; fall = -1;
        resetn = 1'b1;
        for (int c = 0; c < 5000; c++) begin
            tick();
            if (p_start) st.push_back({p_x0, p_y0, p_color});
            if (ack != 0) acks++;
            if (p_done) last_done = c;
            if (!clear_busy) begin
                fall = c;
                break;
            end
        end
        checks++;
        if (fall < 0) begin failures++; $display("FAIL sweep_end clear_busy still high"); end
        checks++;
        if (st.size() != 200) begin failures++; $display("FAIL sweep_count got=%0d exp=200", st.size()); end
        for (int i = 0; i < 200 && i < st.size(); i++) begin
            expv = {10'((i % 10) * 64), 9'((i / 10) * 24), 9'd0};
            checks++;
            if (st[i] !== expv) begin
                failures++;
                $display("FAIL sweep_cell[%0d] got=%h exp=%h", i, st[i], expv);
            end
        end
        checks++;
        if (acks != 0) begin failures++; $display("FAIL sweep_no_ack got=%0d exp=0", acks); end
        checks++;
        if (fall != last_done + 1) begin
            failures++;
            $display("FAIL sweep_busy_fall got=%0d exp=%0d", fall, last_done + 1);
        end
    endtask

    task automatic test_single();
        int seen;
        logic ok;
        set_req(1, 3, 7, 9'h1C7);
        req = 4'b0010;
        tick();
        checks++;
        if ({p_start, p_x0, p_y0, p_color} !== {1'b1, 10'd192, 9'd168, 9'h1C7}) begin
            failures++;
            $display("FAIL single_issue got=%b/%0d/%0d/%h exp=1/192/168/1c7", p_start, p_x0, p_y0, p_color);
        end
        ok = 1'b0;
        for (int c = 0; c < 100; c++) begin
            tick();
            if (p_done) begin ok = 1'b1; break; end
        end
        checks++;
        if (!ok) begin failures++; $display("FAIL single_done got=none exp=p_done"); end
        tick();
        checks++;
        if (ack !== 4'b0010) begin failures++; $display("FAIL single_ack got=%b exp=0010", ack); end
        tick();
        checks++;
        if (ack !== 4'b0000) begin failures++; $display("FAIL single_ack_len got=%b exp=0000", ack); end
        req = '0;
        seen = 0;
        repeat (10) begin tick(); if (p_start) seen++; end
        checks++;
        if (seen != 0) begin failures++; $display("FAIL single_late_drop got=%0d exp=0 starts", seen); end
    endtask

    task automatic test_back_to_back();
        int exp_idx [6] = '{2, 3, 0, 2, 3, 0};
        int n, got;
        set_req(0, 1, 1, 9'h001);
        set_req(2, 2, 2, 9'h002);
        set_req(3, 4, 5, 9'h003);
        req = 4'b1101;
        n = 0;
        for (int c = 0; c < 400 && n < 6; c++) begin
            tick();
            if (p_start) begin
                got = (p_color == 9'h001) ? 0 : (p_color == 9'h002) ? 2 : (p_color == 9'h003) ? 3 : -1;
                checks++;
                if (got != exp_idx[n]) begin
                    failures++;
                    $display("FAIL b2b_grant[%0d] got=%0d exp=%0d", n, got, exp_idx[n]);
                end
                n++;
                if (n == 6) req = '0;
            end
        end
        checks++;
        if (n != 6) begin failures++; $display("FAIL b2b_count got=%0d exp=6", n); end
        repeat (20) tick();
    endtask

    task automatic test_clear_during_wait();
        logic [27:0] st[$];
        logic ok, early, pulsed, drop;
        int acks;
        set_req(2, 5, 9, 9'h0AA);
        req = 4'b0100;
        ok = 1'b0;
        for (int c = 0; c < 20; c++) begin tick(); if (p_start) begin ok = 1'b1; break; end end
        checks++;
        if (!ok) begin failures++; $display("FAIL cw_issue got=none exp=p_start"); end
        tick(); clear_req = 1'b1;
        tick(); clear_req = 1'b0;
        ok = 1'b0; early = 1'b0;
        for (int c = 0; c < 50; c++) begin
            tick();
            if (p_start) early = 1'b1;
            if (ack != 0) begin ok = 1'b1; break; end
        end
        checks++;
        if (!ok || early || ack !== 4'b0100 || !clear_busy) begin
            failures++;
            $display("FAIL cw_ack_first got=ack%b busy%b early%b exp=ack0100 busy1 early0", ack, clear_busy, early);
        end
        req = '0;
        acks = 0; pulsed = 1'b0; drop = 1'b0; ok = 1'b0;
        for (int c = 0; c < 5000; c++) begin
            tick();
            if (drop) begin clear_req = 1'b0; drop = 1'b0; end
            if (p_start) st.push_back({p_x0, p_y0, p_color});
            if (ack != 0) acks++;
            if (st.size() == 50 && !pulsed) begin clear_req = 1'b1; pulsed = 1'b1; drop = 1'b1; end
            if (!clear_busy) begin ok = 1'b1; break; end
        end
        checks++;
        if (!ok || st.size() != 200) begin
            failures++;
            $display("FAIL cw_sweep_len got=%0d exp=200", st.size());
        end
        checks++;
        if (st.size() == 0 || st[0] !== 28'd0) begin failures++; $display("FAIL cw_sweep_first exp=0"); end
        checks++;
        if (acks != 0) begin failures++; $display("FAIL cw_sweep_ack got=%0d exp=0", acks); end
    endtask

    task automatic test_timeout();
        logic ok;
        int n;
        hang = 1'b1;
        set_req(3, 0, 0, 9'h155);
        req = 4'b1000;
        ok = 1'b0;
        for (int c = 0; c < 20; c++) begin tick(); if (p_start) begin ok = 1'b1; break; end end
        checks++;
        if (!ok || err_timeout !== 1'b0) begin
            failures++;
            $display("FAIL to_issue got=start%b err%b exp=start1 err0", ok, err_timeout);
        end
        n = 0;
        for (int c = 0; c < TOUT + 50; c++) begin
            tick(); n++;
            if (ack != 0) break;
        end
        checks++;
        if (n != TOUT + 1 || ack !== 4'b1000 || err_timeout !== 1'b1) begin
            failures++;
            $display("FAIL to_ack got=cyc%0d ack%b err%b exp=cyc%0d ack1000 err1", n, ack, err_timeout, TOUT + 1);
        end
        req = '0; hang = 1'b0;
        tick();
        set_req(0, 9, 19, 9'h1FF);
        req = 4'b0001;
        tick();
        checks++;
        if ({p_start, p_x0, p_y0, p_color} !== {1'b1, 10'd576, 9'd456, 9'h1FF}) begin
            failures++;
            $display("FAIL to_next_issue got=%b/%0d/%0d/%h exp=1/576/456/1ff", p_start, p_x0, p_y0, p_color);
        end
        ok = 1'b0;
        for (int c = 0; c < 50; c++) begin tick(); if (ack != 0) begin ok = 1'b1; break; end end
        req = '0;
        checks++;
        if (!ok || ack !== 4'b0001 || err_timeout !== 1'b1) begin
            failures++;
            $display("FAIL to_next_ack got=ack%b err%b exp=ack0001 err1", ack, err_timeout);
        end
        repeat (3) tick();
    endtask

    task automatic test_range_and_reset();
        logic [35:0] got;
        logic ok;
        int seen, acks;
        checks++;
        if (err_range !== 1'b0) begin failures++; $display("FAIL rng_pre got=%b exp=0", err_range); end
        set_req(0, 12, 0, 9'h0F0);
        req = 4'b0001;
        tick();
        checks++;
        if ({p_start, ack, err_range} !== {1'b0, 4'b0001, 1'b1}) begin
            failures++;
            $display("FAIL rng_ack got=start%b ack%b err%b exp=start0 ack0001 err1", p_start, ack, err_range);
        end
        req = '0;
        seen = 0; acks = 0;
        repeat (5) begin tick(); if (p_start) seen++; if (ack != 0) acks++; end
        checks++;
        if (seen != 0 || acks != 0) begin
            failures++;
            $display("FAIL rng_quiet got=starts%0d acks%0d exp=0/0", seen, acks);
        end
        set_req(1, 2, 3, 9'h0C3);
        req = 4'b0010;
        ok = 1'b0;
        for (int c = 0; c < 20; c++) begin tick(); if (p_start) begin ok = 1'b1; break; end end
        tick(); tick();
        resetn = 1'b0;
        tick();
        got = {p_start, p_x0, p_y0, p_color, ack, err_timeout, err_range, clear_busy};
        checks++;
        if (!ok || got !== {1'b0, 10'd0, 9'd0, 9'd0, 4'd0, 1'b0, 1'b0, 1'b1}) begin
            failures++;
            $display("FAIL midop_reset got=%h issued=%b exp=%h", got, ok, {1'b0, 10'd0, 9'd0, 9'd0, 4'd0, 3'b001});
        end
        req = '0;
        tick();
        resetn = 1'b1;
        acks = 0;
        repeat (30) begin tick(); if (ack != 0) acks++; end
        checks++;
        if (acks != 0) begin failures++; $display("FAIL midop_no_ack got=%0d exp=0", acks); end
    endtask

    initial begin
        test_reset();
        test_clear_sweep();
        test_single();
        test_back_to_back();
        test_clear_during_wait();
        test_timeout();
        test_range_and_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
